// File: rtl/ps2_tx_mouse_if.sv
// Command handshake between a host controller and the PS/2 host-to-device transmitter.
// The master drives the request and byte; the slave (transmitter) reports status pulses.
interface ps2_tx_mouse_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_tx_mouse.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift a byte out on device clocks
// and check the ACK. Define PS2_TX_RETRY_EN to retry failed attempts up to RETRY_MAX times.
module ps2_tx_mouse #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned RTS_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned RETRY_MAX      = 2
) (
  input  logic          clk,
  input  logic          reset,
  ps2_tx_mouse_if.slave tx,
  inout  wire           ps2clk,
  inout  wire           ps2data
);

  localparam int unsigned PhaseMax = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PhaseW-1:0]   InhibitLast = PhaseW'(INHIBIT_CYCLES - 1);
  localparam logic [PhaseW-1:0]   RtsLast     = PhaseW'(RTS_CYCLES - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || RTS_CYCLES < 1 || TIMEOUT_CYCLES < 2 || RETRY_MAX > 15)
  begin : gen_param_check
    $error("ps2_tx_mouse: illegal parameter value");
  end

  typedef enum logic [3:0] {
    StIdle,
    StInhibit,
    StRts,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle,
    StFail
  } state_e;

  state_e                state_q, state_d;
  logic [PhaseW-1:0]     phase_cnt_q;
  logic [TimeoutW-1:0]   timeout_cnt_q;
  logic [7:0]            data_q;
  logic [2:0]            bit_idx_q;
  logic                  bit_q;
  logic [2:0]            clk_sync_q;
  logic [2:0]            data_sync_q;
  logic                  done_q;
  logic                  error_q;

  logic clk_fall;
  logic line_clk;
  logic line_data;
  logic in_xfer;
  logic timed_out;
  logic retry_ok;
  logic parity;
  logic clk_low;
  logic data_low;

  // Stage 0 is the newest sample; a fall is seen when the newer stage is low and the older high.
  assign clk_fall  = ~clk_sync_q[1] & clk_sync_q[2];
  assign line_clk  = clk_sync_q[2];
  assign line_data = data_sync_q[2];
  assign parity    = ~^data_q;
  assign in_xfer   = (state_q == StStart) || (state_q == StData) || (state_q == StParity) ||
                     (state_q == StStop) || (state_q == StWaitIdle);
  assign timed_out = in_xfer && (timeout_cnt_q == TimeoutLast);

`ifdef PS2_TX_RETRY_EN
  logic [3:0] retry_q;

  assign retry_ok = (retry_q < 4'(RETRY_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      retry_q <= '0;
    end else if ((state_q == StIdle) && tx.tx_start) begin
      retry_q <= '0;
    end else if ((state_q == StFail) && retry_ok) begin
      retry_q <= retry_q + 4'd1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (tx.tx_start) state_d = StInhibit;
      StInhibit:  if (phase_cnt_q == InhibitLast) state_d = StRts;
      StRts:      if (phase_cnt_q == RtsLast) state_d = StStart;
      StStart:    if (clk_fall) state_d = StData;
      StData:     if (clk_fall && (bit_idx_q == 3'd0)) state_d = StParity;
      StParity:   if (clk_fall) state_d = StStop;
      StStop:     if (clk_fall) state_d = line_data ? StFail : StWaitIdle;
      StWaitIdle: if (line_clk && line_data) state_d = StIdle;
      StFail:     state_d = retry_ok ? StInhibit : StIdle;
      default:    state_d = StIdle;
    endcase
    if (timed_out) state_d = StFail;
  end

  // Datapath: synchronizers, counters, shift control and status pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_q    <= 3'b111;
      data_sync_q   <= 3'b111;
      phase_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      data_q        <= '0;
      bit_idx_q     <= '0;
      bit_q         <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2clk};
      data_sync_q <= {data_sync_q[1:0], ps2data};
      done_q      <= (state_q == StWaitIdle) && (state_d == StIdle);
      error_q     <= (state_q == StFail) && (state_d == StIdle);

      case (state_q)
        StIdle: begin
          if (tx.tx_start) begin
            data_q        <= tx.tx_data;
            phase_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            bit_idx_q     <= '0;
            bit_q         <= 1'b1;
          end
        end
        StInhibit: begin
          phase_cnt_q <= (state_d == StRts) ? '0 : phase_cnt_q + PhaseW'(1);
        end
        StRts: begin
          if (state_d == StStart) begin
            phase_cnt_q   <= '0;
            timeout_cnt_q <= '0;
          end else begin
            phase_cnt_q <= phase_cnt_q + PhaseW'(1);
          end
        end
        StStart, StData, StParity, StStop, StWaitIdle: begin
          timeout_cnt_q <= timeout_cnt_q + TimeoutW'(1);
          if (clk_fall && (state_q == StStart)) begin
            bit_q     <= data_q[0];
            bit_idx_q <= 3'd1;
          end else if (clk_fall && (state_q == StData)) begin
            // Index wraps to zero once d7 is out, which selects the parity bit next.
            bit_q     <= (bit_idx_q == 3'd0) ? parity : data_q[bit_idx_q];
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        StFail: begin
          phase_cnt_q   <= '0;
          timeout_cnt_q <= '0;
          bit_idx_q     <= '0;
          bit_q         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output logic: open-drain line pulls
  always_comb begin
    clk_low  = 1'b0;
    data_low = 1'b0;
    case (state_q)
      StInhibit: clk_low = 1'b1;
      StRts: begin
        clk_low  = 1'b1;
        data_low = 1'b1;
      end
      StStart:          data_low = 1'b1;
      StData, StParity: data_low = ~bit_q;
      default: ;
    endcase
  end

  assign ps2clk  = clk_low  ? 1'b0 : 1'bz;
  assign ps2data = data_low ? 1'b0 : 1'bz;

  assign tx.tx_busy  = (state_q != StIdle);
  assign tx.tx_done  = done_q;
  assign tx.tx_error = error_q;

endmodule
